shiftreg_ctrl: RTL

- SPI-style master that sequences the MIDI switcher's serial routing shift registers.
- Accepts an N-bit routing word via a start/ready/done handshake, then drives spi_clk (derived from clk) and shifts the word out MSB first on spi_mosi.
- Captures the word returned on spi_miso, then pulses latch so downstream registers update their outputs.
- Sits between the routing-table logic and the external or test shift-register chain.

---
 rtl/shiftreg_ctrl_pkg.sv | 35 +++
 rtl/spi_phase_timer.sv | 52 +++++
 rtl/shiftreg_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// shiftreg_ctrl_pkg
//   Shared definitions for the routing shift-register controller:
//   - controller state encoding (IDLE, LOW, HIGH, LATCH, DONE)
//   - clog2 helper used to size the phase, bit and latch counters
//   - default word width, spi_clk divider and latch hold length
// ----------------------------------------------------------------------------
package shiftreg_ctrl_pkg;

   // Default shift word width in bits.
   localparam int DEF_N            = 8;
   // Default clk cycles per spi_clk half-period.
   localparam int DEF_CLK_DIV      = 4;
   // Default clk cycles latch stays high after the last falling edge.
   localparam int DEF_LATCH_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOW   = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Number of bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : shiftreg_ctrl_pkg

// File: rtl/spi_phase_timer.sv
// ----------------------------------------------------------------------------
// spi_phase_timer
//   Counts CLK_DIV clk cycles per spi_clk half-period and flags the last
//   cycle of each half-period. Shared by the LOW and HIGH phases.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   en        in   count while high (controller is in LOW or HIGH)
//   restart   in   force the count back to 0 so the next phase starts aligned
//   phase_end out  high on the last cycle of a half-period (combinational
//                  decode of the count, consumed by the controller's flops)
// ----------------------------------------------------------------------------
module spi_phase_timer
   import shiftreg_ctrl_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic phase_end
);

   localparam int            PW   = clog2(CLK_DIV);
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (en) begin
         // Wrap at the half-period boundary so LOW and HIGH chain seamlessly.
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign phase_end = en && !restart && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : spi_phase_timer

// File: rtl/shiftreg_ctrl.sv
// ----------------------------------------------------------------------------
// shiftreg_ctrl
//   SPI-style master for the MIDI switcher's serial routing shift registers.
//   Accepts an N-bit routing word on a start/ready handshake, shifts it out
//   MSB first on spi_mosi with a divided spi_clk, shifts spi_miso into a
//   receive buffer on the last cycle of every HIGH phase, then pulses latch
//   and reports completion with a one-cycle done.
//
// Ports:
//   clk       in   system clock, all logic on its rising edge
//   reset     in   synchronous, active-high reset (aborts any transfer)
//   start     in   transfer request, honoured only while ready=1
//   tx_data   in   [N] word to send, captured when start is accepted
//   ready     out  high while idle
//   done      out  one-cycle pulse once shifting and latch are complete
//   rx_data   out  [N] word shifted in from spi_miso, updated with done
//   spi_clk   out  serial clock, registered, idle low
//   spi_mosi  out  serial data to the chain's din
//   spi_miso  in   serial data from the chain's dout
//   latch     out  storage-register strobe, active high
//
// Timing: start accepted in cycle 0, LOW phases begin in cycle 1, done is
// high in cycle 2*CLK_DIV*N + LATCH_CYCLES + 1.
// ----------------------------------------------------------------------------
module shiftreg_ctrl
   import shiftreg_ctrl_pkg::*;
#(
   parameter int N            = DEF_N,
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] tx_data,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] rx_data,
   output logic         spi_clk,
   output logic         spi_mosi,
   input  logic         spi_miso,
   output logic         latch
);

   localparam int            BW       = clog2(N);
   localparam int            LW       = clog2(LATCH_CYCLES + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

   // Control state and registered outputs.
   state_t        state_q,    state_d;
   logic          spi_clk_q,  spi_clk_d;
   logic          spi_mosi_q, spi_mosi_d;
   logic          latch_q,    latch_d;
   logic          done_q,     done_d;
   logic          ready_q,    ready_d;
   logic [N-1:0]  rx_data_q,  rx_data_d;
   logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
   logic [LW-1:0] lat_cnt_q,  lat_cnt_d;

   // Shift buffers (data only, never reset).
   // tx_buf holds the bits still to be sent after the one on spi_mosi,
   // so its MSB is always the next bit to present.
   logic [N-1:0]  tx_buf_q,   tx_buf_d;
   logic [N-1:0]  rx_buf_q,   rx_buf_d;

   logic          phase_en;
   logic          phase_end;

   assign phase_en = (state_q == ST_LOW) || (state_q == ST_HIGH);

   spi_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk       (clk),
      .reset     (reset),
      .en        (phase_en),
      .restart   (!phase_en),
      .phase_end (phase_end)
   );

   always_comb begin
      state_d    = state_q;
      spi_clk_d  = spi_clk_q;
      spi_mosi_d = spi_mosi_q;
      latch_d    = latch_q;
      done_d     = done_q;
      ready_d    = ready_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      tx_buf_d   = tx_buf_q;
      rx_buf_d   = rx_buf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               spi_mosi_d = tx_data[N-1];
               tx_buf_d   = {tx_data[N-2:0], 1'b0};
               bit_cnt_d  = BIT_LAST;
               ready_d    = 1'b0;
               state_d    = ST_LOW;
            end
         end

         ST_LOW: begin
            if (phase_end) begin
               spi_clk_d = 1'b1;
               state_d   = ST_HIGH;
            end
         end

         ST_HIGH: begin
            if (phase_end) begin
               // Sample as late as possible in HIGH, just before the fall.
               rx_buf_d  = {rx_buf_q[N-2:0], spi_miso};
               spi_clk_d = 1'b0;
               if (bit_cnt_q != '0) begin
                  bit_cnt_d  = bit_cnt_q - 1'b1;
                  spi_mosi_d = tx_buf_q[N-1];
                  tx_buf_d   = {tx_buf_q[N-2:0], 1'b0};
                  state_d    = ST_LOW;
               end else begin
                  spi_mosi_d = 1'b0;
                  latch_d    = 1'b1;
                  lat_cnt_d  = LAT_LAST;
                  state_d    = ST_LATCH;
               end
            end
         end

         ST_LATCH: begin
            if (lat_cnt_q == '0) begin
               latch_d   = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_buf_q;
               state_d   = ST_DONE;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            done_d  = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            spi_clk_d  = 1'b0;
            spi_mosi_d = 1'b0;
            latch_d    = 1'b0;
            done_d     = 1'b0;
            ready_d    = 1'b1;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         spi_clk_q  <= 1'b0;
         spi_mosi_q <= 1'b0;
         latch_q    <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         lat_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         spi_clk_q  <= spi_clk_d;
         spi_mosi_q <= spi_mosi_d;
         latch_q    <= latch_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      tx_buf_q <= tx_buf_d;
      rx_buf_q <= rx_buf_d;
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign rx_data  = rx_data_q;
   assign spi_clk  = spi_clk_q;
   assign spi_mosi = spi_mosi_q;
   assign latch    = latch_q;

endmodule : shiftreg_ctrl
